// File: rtl/mips_pkg.sv
// Shared datapath constants and writeback types for the MIPS core.
package mips_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } wb_pri_e;

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding register with a valid/ready input side.
module wb_slot #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              grant,
    output logic              ready_c,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    // A granted slot empties this cycle, so it can be refilled at the same edge.
    assign ready_c = !full || grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (in_valid && ready_c) begin
            full <= 1'b1;
            addr <= in_addr;
            data <= in_data;
        end else if (grant) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/word_mux2.sv
// Generic 2:1 word multiplexer used throughout the datapath.
module word_mux2
    import mips_pkg::*;
#(
    parameter int unsigned W = WORD_W
) (
    input  logic         sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    output logic [W-1:0] y_c
);

    assign y_c = sel ? d1 : d0;

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the
// ALU and load writeback streams, with a saturating contention counter.
module wb_port_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = WORD_W,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              stall,
    output logic              mux_sel,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic              full_a, full_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] data_a, data_b;
    logic              grant_a, grant_b, grant_any, contend;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    wb_pri_e           pri_q, pri_d;

    wb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (a_valid),
        .in_addr  (a_addr),
        .in_data  (a_data),
        .grant    (grant_a),
        .ready_c  (a_ready),
        .full     (full_a),
        .addr     (addr_a),
        .data     (data_a)
    );

    wb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (b_valid),
        .in_addr  (b_addr),
        .in_data  (b_data),
        .grant    (grant_b),
        .ready_c  (b_ready),
        .full     (full_b),
        .addr     (addr_b),
        .data     (data_b)
    );

    // Priority only matters, and only rotates, when both slots compete.
    assign contend   = full_a && full_b && !stall;
    assign grant_a   = !stall && full_a && (!full_b || (pri_q == PRI_A));
    assign grant_b   = !stall && full_b && (!full_a || (pri_q == PRI_B));
    assign grant_any = grant_a || grant_b;
    assign mux_sel   = grant_b;

    word_mux2 #(.W(DATA_W)) u_data_mux (
        .sel (mux_sel),
        .d0  (data_a),
        .d1  (data_b),
        .y_c (sel_data)
    );

    assign sel_addr = mux_sel ? addr_b : addr_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri_q <= PRI_A;
        end else begin
            pri_q <= pri_d;
        end
    end

    always_comb begin
        pri_d = pri_q;
        if (contend) begin
            pri_d = grant_a ? PRI_B : PRI_A;
        end
    end

    // Writes to $zero still drain their slot but never reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (grant_any) begin
            wr_en   <= (sel_addr != '0);
            wr_addr <= sel_addr;
            wr_data <= sel_data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (contend && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed writeback traffic, expected
// writes queued at issue time and checked by a negedge monitor.
module tb_wb_port_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid, b_valid, a_ready, b_ready, stall;
    logic [AW-1:0] a_addr, b_addr, wr_addr;
    logic [DW-1:0] a_data, b_data, wr_data;
    logic          mux_sel, wr_en;
    logic [CW-1:0] conflict_cnt;

    int total = 0;
    int bad   = 0;
    logic [AW+DW-1:0] exp_q[$];

    wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_addr       (a_addr),
        .a_data       (a_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_addr       (b_addr),
        .b_data       (b_data),
        .stall        (stall),
        .mux_sel      (mux_sel),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write the DUT issues must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h expected none at %0t",
                         wr_addr, wr_data, $time);
            end else begin
                chk("write", 64'({wr_addr, wr_data}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Both streams valid for n edges (n even): n+1 writes alternating A/B, ending on A.
    task automatic run_contention(input int n);
        for (int k = 0; k <= n; k++) begin
            if (k % 2 == 0) exp_q.push_back({AW'(1), DW'(32'h11)});
            else            exp_q.push_back({AW'(2), DW'(32'h22)});
        end
        a_valid = 1'b1; a_addr = AW'(1); a_data = DW'(32'h11);
        b_valid = 1'b1; b_addr = AW'(2); b_data = DW'(32'h22);
        step();
        @(negedge clk);
        chk("first_grant_sel", 64'(mux_sel), 64'(0));
        chk("first_grant_b_ready", 64'(b_ready), 64'(0));
        step();
        @(negedge clk);
        chk("second_grant_sel", 64'(mux_sel), 64'(1));
        chk("second_grant_a_ready", 64'(a_ready), 64'(0));
        repeat (n - 2) step();
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;

        // Single ALU write
        do_reset();
        @(negedge clk);
        chk("rst_a_ready", 64'(a_ready), 64'(1));
        chk("rst_b_ready", 64'(b_ready), 64'(1));
        chk("rst_mux_sel", 64'(mux_sel), 64'(0));
        chk("rst_wr_en", 64'(wr_en), 64'(0));
        chk("rst_wr_addr", 64'(wr_addr), 64'(0));
        chk("rst_wr_data", 64'(wr_data), 64'(0));
        chk("rst_cnt", 64'(conflict_cnt), 64'(0));
        a_valid = 1'b1; a_addr = AW'(5); a_data = DW'(32'hDEADBEEF);
        exp_q.push_back({AW'(5), DW'(32'hDEADBEEF)});
        step();
        a_valid = 1'b0;
        @(negedge clk);
        chk("single_mux_sel", 64'(mux_sel), 64'(0));
        chk("single_wr_en_n1", 64'(wr_en), 64'(0));
        step();
        @(negedge clk);
        chk("single_wr_en_n2", 64'(wr_en), 64'(1));
        step();
        @(negedge clk);
        chk("single_cnt", 64'(conflict_cnt), 64'(0));

        // Alternating contention for 6 cycles
        do_reset();
        run_contention(6);
        @(negedge clk);
        chk("alt_cnt", 64'(conflict_cnt), 64'(6));

        // Load to $zero drains silently
        b_valid = 1'b1; b_addr = AW'(0); b_data = DW'(32'hFFFFFFFF);
        step();
        b_valid = 1'b0;
        @(negedge clk);
        chk("zero_grant_sel", 64'(mux_sel), 64'(1));
        chk("zero_b_ready", 64'(b_ready), 64'(1));
        step();
        @(negedge clk);
        chk("zero_wr_en", 64'(wr_en), 64'(0));
        chk("zero_b_ready_after", 64'(b_ready), 64'(1));

        // Stall with both slots full
        do_reset();
        stall = 1'b1;
        a_valid = 1'b1; a_addr = AW'(3); a_data = DW'(32'h33);
        b_valid = 1'b1; b_addr = AW'(4); b_data = DW'(32'h44);
        exp_q.push_back({AW'(3), DW'(32'h33)});
        exp_q.push_back({AW'(4), DW'(32'h44)});
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_wr_en", 64'(wr_en), 64'(0));
            chk("stall_a_ready", 64'(a_ready), 64'(0));
            chk("stall_b_ready", 64'(b_ready), 64'(0));
            step();
        end
        stall = 1'b0;
        @(negedge clk);
        chk("unstall_first_sel", 64'(mux_sel), 64'(0));
        chk("unstall_cnt0", 64'(conflict_cnt), 64'(0));
        repeat (4) step();
        @(negedge clk);
        chk("unstall_cnt", 64'(conflict_cnt), 64'(1));

        // Reset while both slots are full
        do_reset();
        a_valid = 1'b1; a_addr = AW'(7); a_data = DW'(32'h77);
        b_valid = 1'b1; b_addr = AW'(8); b_data = DW'(32'h88);
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", 64'(wr_en), 64'(0));
        chk("midrst_a_ready", 64'(a_ready), 64'(1));
        chk("midrst_b_ready", 64'(b_ready), 64'(1));
        chk("midrst_mux_sel", 64'(mux_sel), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("postrst_wr_en", 64'(wr_en), 64'(0));
            step();
        end

        // Counter saturation
        do_reset();
        run_contention(20);
        @(negedge clk);
        chk("sat_cnt", 64'(conflict_cnt), 64'(15));

        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
